// File: rtl/clk_sched_ctrl_pkg.sv
// Shared types and defaults for the clock scheduler: state and command encodings.
package clk_ctrl_pkg;

    localparam int DIV_W_DEF       = 8;
    localparam int BURST_W_DEF     = 16;
    localparam int DEFAULT_DIV_DEF = 4;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BURST = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_HALT  = 2'd0,
        OP_RUN   = 2'd1,
        OP_STEP  = 2'd2,
        OP_BURST = 2'd3
    } cmd_op_e;

    // Any state other than HALT is allowed to issue ticks.
    function automatic logic isActive(input state_e s);
        return s != ST_HALT;
    endfunction

    function automatic logic canAccept(input state_e s);
        return (s == ST_HALT) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/clk_sched_ctrl_if.sv
// Command, divider and tick-output bundle between the debug front end and the scheduler.
interface clk_sched_ctrl_if
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) ();

    logic [DIV_W-1:0]   div_val;
    logic               div_load;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [BURST_W-1:0] burst_len;
    logic               halt_req;
    logic               tick_en;
    logic               clk_out;
    logic               done;
    logic [1:0]         state;

    modport master (
        output div_val, div_load, cmd_valid, cmd_op, burst_len, halt_req,
        input  cmd_ready, tick_en, clk_out, done, state
    );

    modport slave (
        input  div_val, div_load, cmd_valid, cmd_op, burst_len, halt_req,
        output cmd_ready, tick_en, clk_out, done, state
    );

endinterface

// File: rtl/clk_sched_ctrl_prescaler.sv
// Free-running prescaler counting 0..div_reg-1; o_wrap is high during the last count.
module clk_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [DIV_W-1:0] i_divReg,
    input  logic             i_clear,
    output logic             o_wrap
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;

    // >= guards against a stale count should the ratio ever shrink without a clear.
    assign o_wrap = (r_cnt >= (i_divReg - ONE));

    always_ff @(posedge clk_in) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (o_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + ONE;
        end
    end

endmodule

// File: rtl/clk_sched_ctrl.sv
// Controlled tick source with RUN/HALT/STEP/BURST; BURST is built only when
// CLKCTRL_BURST_EN is defined, otherwise cmd_op=11 is an accepted no-op.
module clk_sched_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    parameter int BURST_W     = BURST_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    clk_sched_ctrl_if.slave  bus
);

    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);

    state_e           r_state;
    state_e           w_nextState;
    logic [DIV_W-1:0] r_divReg;
    logic             r_tickEn;
    logic             r_clkOut;
    logic             r_done;

    logic             w_wrap;
    logic             w_ready;
    logic             w_accept;
    logic             w_haltForce;
    logic             w_take;
    logic             w_opGo;
    logic             w_clear;
    logic             w_tick;
    logic             w_doneNext;
    logic             w_burstZero;
    logic             w_burstLast;

`ifdef CLKCTRL_BURST_EN
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    logic [BURST_W-1:0] r_remain;
    logic               r_zeroPend;
`endif

    // halt_req outranks any command arriving on the same edge, including its prescaler clear.
    assign w_accept    = bus.cmd_valid && w_ready;
    assign w_haltForce = isActive(r_state) && bus.halt_req;
    assign w_take      = w_accept && !w_haltForce;
    assign w_tick      = w_wrap && isActive(r_state) && !bus.halt_req;
    assign w_clear     = bus.div_load || w_opGo;

    always_comb begin
        w_opGo      = 1'b0;
        w_burstZero = 1'b0;
        w_burstLast = 1'b0;
        if (w_take) begin
            case (cmd_op_e'(bus.cmd_op))
                OP_RUN, OP_STEP: w_opGo = 1'b1;
`ifdef CLKCTRL_BURST_EN
                OP_BURST: begin
                    w_opGo      = 1'b1;
                    w_burstZero = (bus.burst_len == '0);
                end
`endif
                default: w_opGo = 1'b0;
            endcase
        end
`ifdef CLKCTRL_BURST_EN
        w_burstLast = (r_state == ST_BURST) && w_tick && (r_remain == BURST_ONE);
`endif
    end

    clk_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk_in   (clk_in),
        .rst      (rst),
        .i_divReg (r_divReg),
        .i_clear  (w_clear),
        .o_wrap   (w_wrap)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state <= ST_HALT;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (w_haltForce) begin
            w_nextState = ST_HALT;
        end else begin
            case (r_state)
                ST_HALT, ST_RUN: begin
                    if (w_take) begin
                        case (cmd_op_e'(bus.cmd_op))
                            OP_HALT: w_nextState = ST_HALT;
                            OP_RUN:  w_nextState = ST_RUN;
                            OP_STEP: w_nextState = ST_STEP;
`ifdef CLKCTRL_BURST_EN
                            OP_BURST: w_nextState = w_burstZero ? ST_HALT : ST_BURST;
`endif
                            default: w_nextState = r_state;
                        endcase
                    end
                end
                ST_STEP: begin
                    if (w_tick) begin
                        w_nextState = ST_HALT;
                    end
                end
`ifdef CLKCTRL_BURST_EN
                ST_BURST: begin
                    if (w_burstLast) begin
                        w_nextState = ST_HALT;
                    end
                end
`endif
                default: w_nextState = r_state;
            endcase
        end
    end

    // A zero-length burst reports completion one edge after it was accepted.
    always_comb begin
        w_ready    = canAccept(r_state) && !rst;
        w_doneNext = ((r_state == ST_STEP) && w_tick) || w_burstLast;
`ifdef CLKCTRL_BURST_EN
        w_doneNext = w_doneNext || r_zeroPend;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_divReg <= DIV_RESET;
            r_tickEn <= 1'b0;
            r_clkOut <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_tickEn <= w_tick;
            r_clkOut <= r_clkOut ^ w_tick;
            r_done   <= w_doneNext;
            if (bus.div_load) begin
                r_divReg <= (bus.div_val == '0) ? DIV_ONE : bus.div_val;
            end
        end
    end

`ifdef CLKCTRL_BURST_EN
    // The remaining count survives div_load; only a new burst, a tick or a halt touches it.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_remain   <= '0;
            r_zeroPend <= 1'b0;
        end else begin
            r_zeroPend <= w_burstZero;
            if (w_haltForce) begin
                r_remain <= '0;
            end else if (w_take && (cmd_op_e'(bus.cmd_op) == OP_BURST)) begin
                r_remain <= bus.burst_len;
            end else if ((r_state == ST_BURST) && w_tick) begin
                r_remain <= r_remain - BURST_ONE;
            end
        end
    end
`endif

    assign bus.cmd_ready = w_ready;
    assign bus.tick_en   = r_tickEn;
    assign bus.clk_out   = r_clkOut;
    assign bus.done      = r_done;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_clk_sched_ctrl.sv
// Self-checking bench for clk_sched_ctrl: directed scenarios then random traffic,
// all checked against a cycle-indexed reference model (honours CLKCTRL_BURST_EN).
module tb_clk_sched_ctrl;

`ifdef CLKCTRL_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    localparam int DEF_DIV = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    clk_sched_ctrl_if #(.DIV_W(8), .BURST_W(16)) bus ();

    clk_sched_ctrl #(
        .DIV_W       (8),
        .DEFAULT_DIV (DEF_DIV),
        .BURST_W     (16)
    ) dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the prescaler is expressed as "edges since last clear modulo ratio".
    bit mValid = 1'b0;
    int edgeIdx = 0;
    int lastClear = 0;
    int mState = 0;
    int mDiv = DEF_DIV;
    int mRemain = 0;
    bit mZeroPend = 1'b0;
    bit mTick = 1'b0;
    bit mClk = 1'b0;
    bit mDone = 1'b0;
    int tickSeen = 0;

    bit       sRst;
    bit       sValid;
    bit [1:0] sOp;
    bit [15:0] sLen;
    bit       sLoad;
    bit [7:0] sDiv;
    bit       sHalt;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", tag, act, exp, edgeIdx);
        end
    endtask

    task automatic modelEdge();
        bit active, ready, accept, haltForce, take, wrap, tick, goOp, zeroNext;
        int nState, nRemain;
        edgeIdx++;
        if (sRst) begin
            mValid = 1'b1;
            mState = 0; mDiv = DEF_DIV; lastClear = edgeIdx; mRemain = 0;
            mZeroPend = 1'b0; mTick = 1'b0; mClk = 1'b0; mDone = 1'b0;
            return;
        end
        if (!mValid) return;
        active    = (mState != 0);
        ready     = (mState == 0) || (mState == 1);
        accept    = sValid && ready;
        haltForce = active && sHalt;
        take      = accept && !haltForce;
        wrap      = ((edgeIdx - lastClear) % mDiv) == 0;
        tick      = wrap && active && !sHalt;
        goOp      = take && ((sOp == 2'd1) || (sOp == 2'd2) || (BURST_EN && sOp == 2'd3));
        mDone     = (mState == 2 && tick) || (mState == 3 && tick && mRemain == 1) || mZeroPend;
        nState    = mState;
        nRemain   = mRemain;
        zeroNext  = 1'b0;
        if (haltForce) begin
            nState = 0;
            nRemain = 0;
        end else if (take) begin
            case (sOp)
                2'd0: nState = 0;
                2'd1: nState = 1;
                2'd2: nState = 2;
                default: if (BURST_EN) begin
                    nRemain = sLen;
                    if (sLen == 0) begin
                        nState = 0;
                        zeroNext = 1'b1;
                    end else begin
                        nState = 3;
                    end
                end
            endcase
        end else if (mState == 2 && tick) begin
            nState = 0;
        end else if (mState == 3 && tick) begin
            nRemain = mRemain - 1;
            if (mRemain == 1) nState = 0;
        end
        if (sLoad || goOp) lastClear = edgeIdx;
        if (sLoad) mDiv = (sDiv == 0) ? 1 : sDiv;
        mTick = tick;
        mClk = mClk ^ tick;
        mState = nState;
        mRemain = nRemain;
        mZeroPend = zeroNext;
    endtask

    task automatic runCycle();
        #1;
        if (mValid) checkOutput("cmd_ready", bus.cmd_ready, 32'(((mState == 0) || (mState == 1)) && !sRst));
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        if (bus.tick_en === 1'b1) tickSeen++;
        if (mValid) begin
            checkOutput("tick_en", bus.tick_en, 32'(mTick));
            checkOutput("clk_out", bus.clk_out, 32'(mClk));
            checkOutput("done", bus.done, 32'(mDone));
            checkOutput("state", bus.state, 32'(mState));
        end
    endtask

    task automatic applyStimulus(input bit r, input bit v, input bit [1:0] op, input bit [15:0] len,
                                 input bit dl, input bit [7:0] dv, input bit h);
        sRst = r; sValid = v; sOp = op; sLen = len; sLoad = dl; sDiv = dv; sHalt = h;
        rst = r;
        bus.cmd_valid = v; bus.cmd_op = op; bus.burst_len = len;
        bus.div_load = dl; bus.div_val = dv; bus.halt_req = h;
        runCycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'd0, 16'd0, 0, 8'd0, 0);
    endtask

    task automatic sendCmd(input bit [1:0] op, input bit [15:0] len);
        applyStimulus(0, 1, op, len, 0, 8'd0, 0);
    endtask

    task automatic loadDiv(input bit [7:0] v);
        applyStimulus(0, 0, 2'd0, 16'd0, 1, v, 0);
    endtask

    int startTicks;

    initial begin
        applyStimulus(1, 0, 2'd0, 16'd0, 0, 8'd0, 0);
        applyStimulus(1, 0, 2'd0, 16'd0, 0, 8'd0, 0);
        checkOutput("reset_state", bus.state, 32'd0);
        checkOutput("reset_tick", bus.tick_en, 32'd0);

        // RUN at the default ratio
        idle(3);
        sendCmd(2'd1, 16'd0);
        startTicks = tickSeen;
        idle(20);
        checkOutput("run_ticks", 32'(tickSeen - startTicks), 32'd5);

        // STEP with ratio 3
        sendCmd(2'd0, 16'd0);
        loadDiv(8'd3);
        startTicks = tickSeen;
        sendCmd(2'd2, 16'd0);
        idle(8);
        checkOutput("step_ticks", 32'(tickSeen - startTicks), 32'd1);

        // BURST of 5 at ratio 2, then a zero-length burst
        loadDiv(8'd2);
        startTicks = tickSeen;
        sendCmd(2'd3, 16'd5);
        idle(14);
        checkOutput("burst_ticks", 32'(tickSeen - startTicks), BURST_EN ? 32'd5 : 32'd0);
        startTicks = tickSeen;
        sendCmd(2'd3, 16'd0);
        idle(4);
        checkOutput("burst0_ticks", 32'(tickSeen - startTicks), 32'd0);

        // halt_req on the edge of the 3rd tick of a 10-burst
        sendCmd(2'd3, 16'd10);
        idle(5);
        applyStimulus(0, 0, 2'd0, 16'd0, 0, 8'd0, 1);
        idle(6);

        // ratio changes while running, including a zero ratio
        loadDiv(8'd4);
        sendCmd(2'd1, 16'd0);
        idle(6);
        loadDiv(8'd1);
        idle(5);
        loadDiv(8'd0);
        startTicks = tickSeen;
        idle(5);
        checkOutput("div0_ticks", 32'(tickSeen - startTicks), 32'd5);
        sendCmd(2'd0, 16'd0);

        // reset in the middle of a burst
        loadDiv(8'd3);
        sendCmd(2'd3, 16'd20);
        idle(5);
        applyStimulus(1, 0, 2'd0, 16'd0, 0, 8'd0, 0);
        checkOutput("midrst_state", bus.state, 32'd0);
        checkOutput("midrst_clk", bus.clk_out, 32'd0);
        sendCmd(2'd1, 16'd0);
        idle(10);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 9) < 3),
                          2'($urandom_range(0, 3)),
                          16'($urandom_range(0, 6)),
                          ($urandom_range(0, 19) == 0),
                          8'($urandom_range(0, 5)),
                          ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_sched_ctrl.md
# clk_sched_ctrl

Clock scheduler for the processor core. It replaces the free-running divided clock with a controlled tick source that supports RUN, HALT, single-STEP and counted-BURST operation. It emits a one-cycle clock-enable (`tick_en`) and a derived square wave (`clk_out`) at a programmable divide ratio. Commands come from the IO/debug front end; `halt_req` comes from the core's halt instruction.

## Interface
- `DIV_W`, default 8: width of the divide ratio.
- `DEFAULT_DIV`, default 4: divide ratio loaded at reset.
- `BURST_W`, default 16: width of the burst length.

- `clk_in`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `div_val`  in  DIV_W  new divide ratio; a value of 0 is treated as 1.
- `div_load`  in  1  load `div_val` this cycle.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted.
- `cmd_op`  in  2  00 HALT, 01 RUN, 10 STEP, 11 BURST.
- `burst_len`  in  BURST_W  tick count for BURST; sampled on accept.
- `halt_req`  in  1  halt request from the core; level-sensitive.
- `tick_en`  out  1  one-cycle clock enable for the core.
- `clk_out`  out  1  toggles on every issued tick.
- `done`  out  1  one-cycle pulse when STEP or BURST completes.
- `state`  out  2  current state, using the package encoding.

## Operation
- **Reset values.** State HALT, `div_reg`=DEFAULT_DIV, prescaler=0, remaining count=0. Outputs: `tick_en`=0, `clk_out`=0, `done`=0, `cmd_ready`=1.
- **Prescaler.**
  - Counts 0..div_reg−1 and wraps.
  - Free-runs in every state.
  - Cleared on `div_load` and on acceptance of RUN, STEP or BURST.
- **Tick rule.** On a wrap edge, `tick_en` is set to 1 for one cycle if the state is RUN, STEP or BURST and `halt_req`=0. Otherwise it is set to 0.
- **clk_out.** Inverts on the same edge that sets `tick_en`. In RUN its period is 2·div_reg cycles.
- **Handshake.**
  - A command is accepted when `cmd_valid` and `cmd_ready` are both high.
  - `cmd_ready` = (state is HALT or RUN) and not `rst`.
  - In STEP or BURST, commands stall until the state returns to HALT.
- **State transitions.**
  - HALT: accepting RUN, STEP or BURST moves to that state. Accepting HALT leaves the state unchanged.
  - RUN: accepting HALT moves to HALT. Accepting STEP or BURST moves directly to that state, with the prescaler cleared.
  - STEP: the first issued tick moves to HALT and pulses `done` on the same edge.
  - BURST:
    - Each tick decrements the remaining count.
    - The tick that takes remaining from 1 to 0 moves to HALT and pulses `done`.
    - `burst_len`=0 moves to HALT on the accept edge. It issues no tick and pulses `done` on the next edge.
- **halt_req.**
  - In RUN, STEP or BURST it forces HALT on the next edge.
  - A tick due on that edge is suppressed.
  - `done` is not pulsed.
  - It has priority over a simultaneous command.
- **Simultaneous div_load and command.** Both take effect. The new ratio applies from prescaler=0.
- **div_load mid-BURST.** The remaining count is preserved.
- **Reset mid-operation.** `rst` overrides everything and gives the reset values on the next edge.

## Timing
- **Command latency.** A command accepted at edge E gives its first `tick_en` in the cycle after edge E+div_reg. With div_reg=1, ticks appear in every cycle from edge E+1.
- **Register stage.** `state` updates on the accept edge. All outputs are registered, with no combinational input-to-output path except `cmd_ready`, which depends on `rst`.
- **Tick spacing.** In RUN and BURST, ticks are exactly div_reg cycles apart.
- **done timing.** `done` coincides with the final tick's `tick_en` cycle.

## Configuration
- **Macro:** `CLKCTRL_BURST_EN`.
- **Defined:** BURST behaves as specified above.
- **Not defined:**
  - The BURST state and the remaining counter are not built.
  - `cmd_op`=11 is accepted as a no-op: state unchanged, no `done`.
  - `burst_len` is ignored.

## Structure
- **Package `clk_ctrl_pkg`:**
  - State encoding: HALT=0, RUN=1, STEP=2, BURST=3.
  - `cmd_op` codes.
  - The DIV_W and BURST_W defaults.
- **Sub-module `clk_prescaler`:**
  - Inputs: div_reg, clear.
  - Output: a one-cycle wrap strobe.
  - The FSM, handshake and tick/`clk_out` registers live in the top module.

## Test plan
1. **RUN at the default ratio.** After reset, accept RUN with div=4. Expect `tick_en` high every 4th cycle, `clk_out` period 8, and `cmd_ready` still 1.
2. **STEP.** In HALT with div=3, accept STEP. Expect exactly one tick 3 cycles after accept, with `done` in the same cycle. State is HALT afterwards and `cmd_ready` stalls for 3 cycles.
3. **BURST of 5 with div=2.** Expect 5 ticks spaced 2 cycles apart and `done` on the 5th. Repeat with `burst_len`=0: expect no tick, HALT, and `done` one cycle after accept.
4. **halt_req during BURST.** Assert `halt_req` on the edge where the 3rd tick is due in a burst of 10. Expect the tick suppressed, state HALT, and no `done`.
5. **div_load in RUN.** Change div from 4 to 1 while in RUN. Expect ticks every cycle starting 1 cycle after the load. Then load div=0 and expect the same behaviour as div=1.
6. **rst asserted mid-BURST.** Expect every output at its reset value on the next edge, and `div_reg`=4.
